// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is stepped over WIDTH cycles, LSB first.
// Operands are captured on start; sum/cout are registered and only change at completion.

module serial_add_fa (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ c;
  assign co = (x & y) | (x & c) | (y & c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic             accept, last;

  serial_add_fa u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result bits enter at the MSB; after WIDTH steps bit 0 has reached position 0.
  assign r_nxt = {fa_s, r_sh};
  assign last  = (cnt == LAST);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    accept = start && (state == IDLE || state == DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nxt[WIDTH-1:1];
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= r_nxt;
        cout <= fa_co;
      end
    end
  end
endmodule
